// File: rtl/wb_arbiter_if.sv
// Write-back bus bundle: load/ALU result offers, register-file write port, forwarding query.
// Latency: none, wires only.
// Backpressure: the Ready signals are driven by the arbiter (slave) back to the offer sources.
//
// Signals:
//   MemValid/MemReg/MemData/MemReady  load result offer and its acceptance
//   AluValid/AluReg/AluData/AluReady  ALU result offer and its acceptance
//   Hold                              register-file write port unavailable this cycle
//   Write1/WriteReg1/WriteData1       register-file write strobe, index and data
//   Pending                           queue occupancy, $clog2(DEPTH)+1 bits
//   QueryReg/QueryHit/QueryData       forwarding lookup into the write queue
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          MemValid;
    logic [4:0]    MemReg;
    logic [31:0]   MemData;
    logic          MemReady;

    logic          AluValid;
    logic [4:0]    AluReg;
    logic [31:0]   AluData;
    logic          AluReady;

    logic          Hold;

    logic          Write1;
    logic [4:0]    WriteReg1;
    logic [31:0]   WriteData1;

    logic [CW-1:0] Pending;

    logic [4:0]    QueryReg;
    logic          QueryHit;
    logic [31:0]   QueryData;

    // Offer sources and register file side.
    modport master (
        output MemValid, MemReg, MemData, AluValid, AluReg, AluData, Hold, QueryReg,
        input  MemReady, AluReady, Write1, WriteReg1, WriteData1, Pending, QueryHit, QueryData
    );

    // The arbiter itself.
    modport slave (
        input  MemValid, MemReg, MemData, AluValid, AluReg, AluData, Hold, QueryReg,
        output MemReady, AluReady, Write1, WriteReg1, WriteData1, Pending, QueryHit, QueryData
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges load and ALU results (load has priority) into a FIFO feeding one register-file write port.
// Latency: an offer accepted at edge N into an empty queue is written during cycle N+1 when Hold is low.
// Backpressure: both Ready outputs drop while the registered occupancy equals DEPTH; Hold stalls the drain only.
//
// Ports:
//   CLK        clock, all state on the rising edge
//   RESET      asynchronous active-low reset; clears pointers and count, discarding queued entries
//   bus        wb_arbiter_if.slave bundle (offers, write port, occupancy, forwarding query)
// Parameter DEPTH: queue entries, power of two 2..16.
// Optional feature macro WB_BYPASS_EN: builds the forwarding lookup (QueryHit/QueryData);
// when undefined both outputs are tied to zero and no comparators exist.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    wb_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Queue state
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    // Entry storage; contents are don't-care outside the valid window so no reset.
    logic [4:0]    reg_mem [DEPTH];
    logic [31:0]   dat_mem [DEPTH];

    logic          full;
    logic          empty;
    logic          mem_rdy;
    logic          alu_rdy;
    logic          mem_acc;
    logic          alu_acc;
    logic [4:0]    push_reg;
    logic [31:0]   push_dat;
    logic          push;
    logic          pop;

    // Full uses the registered count only: a drain in the same cycle does not
    // reopen the queue, which keeps Ready free of any path from Hold.
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // RESET gates the Ready outputs so nothing is accepted while held in reset.
    assign mem_rdy = RESET && !full;
    assign alu_rdy = RESET && !full && !bus.MemValid;

    assign mem_acc = bus.MemValid && mem_rdy;
    assign alu_acc = bus.AluValid && alu_rdy;

    // At most one of mem_acc/alu_acc can be high, so a simple select suffices.
    assign push_reg = mem_acc ? bus.MemReg  : bus.AluReg;
    assign push_dat = mem_acc ? bus.MemData : bus.AluData;

    // Writes to r0 are consumed but never stored.
    assign push = (mem_acc || alu_acc) && (push_reg != 5'd0);
    assign pop  = !empty && !bus.Hold;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            reg_mem[wr_ptr_q] <= push_reg;
            dat_mem[wr_ptr_q] <= push_dat;
        end
    end

    assign bus.MemReady   = mem_rdy;
    assign bus.AluReady   = alu_rdy;
    assign bus.Write1     = pop;
    assign bus.WriteReg1  = empty ? 5'd0  : reg_mem[rd_ptr_q];
    assign bus.WriteData1 = empty ? 32'd0 : dat_mem[rd_ptr_q];
    assign bus.Pending    = cnt_q;

`ifdef WB_BYPASS_EN
    logic          q_hit;
    logic [31:0]   q_dat;
    logic [AW-1:0] q_idx;

    // Walk entries from head (oldest) to tail; a later match overrides an
    // earlier one so the youngest matching entry wins. The head is included
    // even when it is being drained this cycle.
    always_comb begin
        q_hit = 1'b0;
        q_dat = 32'd0;
        q_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_idx = rd_ptr_q + AW'(i);
            if ((CW'(i) < cnt_q) && (bus.QueryReg != 5'd0) &&
                (reg_mem[q_idx] == bus.QueryReg)) begin
                q_hit = 1'b1;
                q_dat = dat_mem[q_idx];
            end
        end
    end

    assign bus.QueryHit  = q_hit;
    assign bus.QueryData = q_dat;
`else
    logic unused_query;
    assign unused_query  = ^bus.QueryReg;
    assign bus.QueryHit  = 1'b0;
    assign bus.QueryData = 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single offer, priority, full/hold, r0 discard, forwarding, mid-run reset.
// Latency: inputs driven 1ns after a rising edge; outputs sampled before the next edge.
// Backpressure: Hold and queue-full behaviour exercised explicitly.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    logic CLK;
    logic RESET;
    int   checks;
    int   fails;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_arbiter #(.DEPTH(DEPTH)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.MemValid = 1'b0;
        bus.MemReg   = 5'd0;
        bus.MemData  = 32'd0;
        bus.AluValid = 1'b0;
        bus.AluReg   = 5'd0;
        bus.AluData  = 32'd0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        idle_inputs();
        bus.Hold     = 1'b0;
        bus.QueryReg = 5'd0;
        bus.MemValid = 1'b1;
        bus.AluValid = 1'b1;
        #1;
        checks++; if (bus.Write1 !== 1'b0) begin fails++; $display("FAIL rst_write1 got %b exp 0", bus.Write1); end
        checks++; if (bus.MemReady !== 1'b0) begin fails++; $display("FAIL rst_memready got %b exp 0", bus.MemReady); end
        checks++; if (bus.AluReady !== 1'b0) begin fails++; $display("FAIL rst_aluready got %b exp 0", bus.AluReady); end
        checks++; if (bus.Pending !== 3'd0) begin fails++; $display("FAIL rst_pending got %0d exp 0", bus.Pending); end
        checks++; if (bus.WriteReg1 !== 5'd0 || bus.WriteData1 !== 32'd0) begin fails++; $display("FAIL rst_wdata got %0d/%h exp 0/0", bus.WriteReg1, bus.WriteData1); end
        checks++; if (bus.QueryHit !== 1'b0 || bus.QueryData !== 32'd0) begin fails++; $display("FAIL rst_query got %b/%h exp 0/0", bus.QueryHit, bus.QueryData); end
        idle_inputs();
        #1 RESET = 1'b1;
        #1;
        checks++; if (bus.MemReady !== 1'b1 || bus.AluReady !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b%b exp 11", bus.MemReady, bus.AluReady); end
        tick();
    endtask

    task automatic test_single_alu();
        bus.AluValid = 1'b1;
        bus.AluReg   = 5'd5;
        bus.AluData  = 32'h1234;
        tick();
        idle_inputs();
        checks++; if (bus.Write1 !== 1'b1) begin fails++; $display("FAIL single_write1 got %b exp 1", bus.Write1); end
        checks++; if (bus.WriteReg1 !== 5'd5) begin fails++; $display("FAIL single_reg got %0d exp 5", bus.WriteReg1); end
        checks++; if (bus.WriteData1 !== 32'h1234) begin fails++; $display("FAIL single_data got %h exp 00001234", bus.WriteData1); end
        checks++; if (bus.Pending !== 3'd1) begin fails++; $display("FAIL single_pending1 got %0d exp 1", bus.Pending); end
        tick();
        checks++; if (bus.Pending !== 3'd0) begin fails++; $display("FAIL single_pending0 got %0d exp 0", bus.Pending); end
        checks++; if (bus.Write1 !== 1'b0 || bus.WriteReg1 !== 5'd0) begin fails++; $display("FAIL single_idle got %b/%0d exp 0/0", bus.Write1, bus.WriteReg1); end
    endtask

    task automatic test_priority();
        bus.MemValid = 1'b1; bus.MemReg = 5'd3; bus.MemData = 32'hA;
        bus.AluValid = 1'b1; bus.AluReg = 5'd4; bus.AluData = 32'hB;
        #1;
        checks++; if (bus.MemReady !== 1'b1 || bus.AluReady !== 1'b0) begin fails++; $display("FAIL prio_ready got %b%b exp 10", bus.MemReady, bus.AluReady); end
        tick();
        bus.MemValid = 1'b0;
        #1;
        checks++; if (bus.AluReady !== 1'b1) begin fails++; $display("FAIL prio_alu_ready got %b exp 1", bus.AluReady); end
        checks++; if (bus.Write1 !== 1'b1 || bus.WriteReg1 !== 5'd3 || bus.WriteData1 !== 32'hA) begin fails++; $display("FAIL prio_first got %b/%0d/%h exp 1/3/0000000a", bus.Write1, bus.WriteReg1, bus.WriteData1); end
        tick();
        idle_inputs();
        // Push and pop on the same edge leave the count at 1.
        checks++; if (bus.Pending !== 3'd1) begin fails++; $display("FAIL prio_pending got %0d exp 1", bus.Pending); end
        checks++; if (bus.Write1 !== 1'b1 || bus.WriteReg1 !== 5'd4 || bus.WriteData1 !== 32'hB) begin fails++; $display("FAIL prio_second got %b/%0d/%h exp 1/4/0000000b", bus.Write1, bus.WriteReg1, bus.WriteData1); end
        tick();
        checks++; if (bus.Pending !== 3'd0) begin fails++; $display("FAIL prio_drained got %0d exp 0", bus.Pending); end
    endtask

    task automatic test_hold_full();
        bus.Hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.AluValid = 1'b1;
            bus.AluReg   = 5'(i);
            bus.AluData  = 32'h100 + 32'(i);
            tick();
        end
        // Keep offering while full; this offer must not be taken.
        bus.AluReg  = 5'd9;
        bus.AluData = 32'hDEAD;
        #1;
        checks++; if (bus.Pending !== 3'd4) begin fails++; $display("FAIL full_pending got %0d exp 4", bus.Pending); end
        checks++; if (bus.MemReady !== 1'b0 || bus.AluReady !== 1'b0) begin fails++; $display("FAIL full_ready got %b%b exp 00", bus.MemReady, bus.AluReady); end
        checks++; if (bus.Write1 !== 1'b0) begin fails++; $display("FAIL full_hold_write got %b exp 0", bus.Write1); end
        bus.Hold = 1'b0;
        #1;
        checks++; if (bus.AluReady !== 1'b0) begin fails++; $display("FAIL full_drain_ready got %b exp 0", bus.AluReady); end
        bus.AluValid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.Write1 !== 1'b1 || bus.WriteReg1 !== 5'(i) || bus.WriteData1 !== 32'h100 + 32'(i)) begin fails++; $display("FAIL full_drain%0d got %b/%0d/%h exp 1/%0d/%h", i, bus.Write1, bus.WriteReg1, bus.WriteData1, i, 32'h100 + 32'(i)); end
            tick();
            if (i == 1) begin
                checks++; if (bus.AluReady !== 1'b1 || bus.Pending !== 3'd3) begin fails++; $display("FAIL full_reopen got %b/%0d exp 1/3", bus.AluReady, bus.Pending); end
            end
        end
        checks++; if (bus.Pending !== 3'd0 || bus.Write1 !== 1'b0) begin fails++; $display("FAIL full_end got %0d/%b exp 0/0", bus.Pending, bus.Write1); end
    endtask

    task automatic test_reg_zero();
        bus.AluValid = 1'b1;
        bus.AluReg   = 5'd0;
        bus.AluData  = 32'hFFFF;
        #1;
        checks++; if (bus.AluReady !== 1'b1) begin fails++; $display("FAIL r0_ready got %b exp 1", bus.AluReady); end
        tick();
        idle_inputs();
        checks++; if (bus.Pending !== 3'd0 || bus.Write1 !== 1'b0) begin fails++; $display("FAIL r0_discard got %0d/%b exp 0/0", bus.Pending, bus.Write1); end
        tick();
        checks++; if (bus.Write1 !== 1'b0) begin fails++; $display("FAIL r0_nowrite got %b exp 0", bus.Write1); end
    endtask

    task automatic test_bypass();
        bus.Hold = 1'b1;
        bus.AluValid = 1'b1; bus.AluReg = 5'd7; bus.AluData = 32'h11;
        tick();
        bus.AluData = 32'h22;
        tick();
        bus.AluReg = 5'd3; bus.AluData = 32'h33;
        tick();
        idle_inputs();
        bus.QueryReg = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        checks++; if (bus.QueryHit !== 1'b1 || bus.QueryData !== 32'h22) begin fails++; $display("FAIL byp_r7 got %b/%h exp 1/00000022", bus.QueryHit, bus.QueryData); end
        bus.QueryReg = 5'd3;
        #1;
        checks++; if (bus.QueryHit !== 1'b1 || bus.QueryData !== 32'h33) begin fails++; $display("FAIL byp_r3 got %b/%h exp 1/00000033", bus.QueryHit, bus.QueryData); end
        bus.QueryReg = 5'd8;
        #1;
        checks++; if (bus.QueryHit !== 1'b0) begin fails++; $display("FAIL byp_r8 got %b exp 0", bus.QueryHit); end
        bus.QueryReg = 5'd0;
        #1;
        checks++; if (bus.QueryHit !== 1'b0) begin fails++; $display("FAIL byp_r0 got %b exp 0", bus.QueryHit); end
        // Drain down to the last entry; the draining head still forwards.
        bus.Hold = 1'b0;
        tick();
        tick();
        bus.QueryReg = 5'd3;
        #1;
        checks++; if (bus.Write1 !== 1'b1 || bus.QueryHit !== 1'b1 || bus.QueryData !== 32'h33) begin fails++; $display("FAIL byp_head got %b/%b/%h exp 1/1/00000033", bus.Write1, bus.QueryHit, bus.QueryData); end
        bus.QueryReg = 5'd7;
        #1;
        checks++; if (bus.QueryHit !== 1'b0) begin fails++; $display("FAIL byp_popped got %b exp 0", bus.QueryHit); end
        tick();
`else
        checks++; if (bus.QueryHit !== 1'b0 || bus.QueryData !== 32'd0) begin fails++; $display("FAIL byp_off got %b/%h exp 0/0", bus.QueryHit, bus.QueryData); end
        bus.Hold = 1'b0;
        tick();
        tick();
        tick();
`endif
        bus.QueryReg = 5'd0;
        checks++; if (bus.Pending !== 3'd0) begin fails++; $display("FAIL byp_drained got %0d exp 0", bus.Pending); end
    endtask

    task automatic test_reset_mid();
        bus.Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.MemValid = 1'b1;
            bus.MemReg   = 5'(10 + i);
            bus.MemData  = 32'hC0 + 32'(i);
            tick();
        end
        idle_inputs();
        checks++; if (bus.Pending !== 3'd3) begin fails++; $display("FAIL mid_pending3 got %0d exp 3", bus.Pending); end
        bus.Hold = 1'b0;
        #1;
        checks++; if (bus.Write1 !== 1'b1) begin fails++; $display("FAIL mid_pre_write got %b exp 1", bus.Write1); end
        RESET = 1'b0;
        #1;
        checks++; if (bus.Write1 !== 1'b0 || bus.Pending !== 3'd0) begin fails++; $display("FAIL mid_async got %b/%0d exp 0/0", bus.Write1, bus.Pending); end
        #2 RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.Write1 !== 1'b0 || bus.Pending !== 3'd0) begin fails++; $display("FAIL mid_after%0d got %b/%0d exp 0/0", i, bus.Write1, bus.Pending); end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_single_alu();
        test_priority();
        test_hold_full();
        test_reg_zero();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning write-queue entries; legal values are powers of two, 2..16.
REQ-002 The block SHALL have port CLK, input, 1 bit, the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port MemValid, input, 1 bit, a load result is offered.
REQ-005 The block SHALL have port MemReg, input, 5 bits, the load destination register.
REQ-006 The block SHALL have port MemData, input, 32 bits, the load data.
REQ-007 The block SHALL have port MemReady, output, 1 bit, the load offer is accepted this cycle.
REQ-008 The block SHALL have ports AluValid, AluReg and AluData, inputs, 1, 5 and 32 bits, the ALU result offer.
REQ-009 The block SHALL have port AluReady, output, 1 bit, the ALU offer is accepted this cycle.
REQ-010 The block SHALL have port Hold, input, 1 bit, register-file write port unavailable, no drain.
REQ-011 The block SHALL have ports Write1, WriteReg1 and WriteData1, outputs, 1, 5 and 32 bits, the register-file write strobe, register index and data.
REQ-012 The block SHALL have port Pending, output, log2(DEPTH)+1 bits, the current queue occupancy.
REQ-013 The block SHALL have port QueryReg, input, 5 bits, the register index to look up in the queue.
REQ-014 The block SHALL have ports QueryHit and QueryData, outputs, 1 and 32 bits, the queue forwarding result.

Function
REQ-015 The block SHALL accept at most one offer per cycle, and a transfer SHALL occur when Valid and Ready are both high at a rising CLK edge.
REQ-016 Arbitration SHALL be fixed-priority, Mem over ALU: MemReady = !full; AluReady = !full && !MemValid.
REQ-017 full SHALL be Pending==DEPTH, evaluated on the registered count with no same-cycle pop pass-through; a full queue SHALL deassert both Ready outputs even when a drain occurs that cycle.
REQ-018 An accepted offer with destination register 0 SHALL be consumed and discarded, and SHALL not be enqueued or counted.
REQ-019 The queue SHALL be FIFO in arrival order, with wrap-around read/write pointers of log2(DEPTH) bits.
REQ-020 Write1 SHALL be !empty && !Hold, and WriteReg1/WriteData1 SHALL be the head entry, combinational from the queue; the head SHALL pop at each edge with Write1 high.
REQ-021 Latency SHALL be: an entry accepted at edge N into an empty queue drives Write1 during cycle N+1 (one write per cycle), provided Hold is low.
REQ-022 When empty, WriteReg1 and WriteData1 SHALL be 0.
REQ-023 Simultaneous push and pop SHALL leave Pending unchanged and update both pointers.
REQ-024 Hold high SHALL freeze the head and keep accepting offers until the queue is full.

Reset
REQ-025 RESET low SHALL asynchronously clear the pointers and count; while RESET is low, Write1=0, MemReady=0, AluReady=0, Pending=0, QueryHit=0, QueryData=0, WriteReg1=0 and WriteData1=0.
REQ-026 Reset mid-operation SHALL discard all queued entries with no write issued, and entry data contents need not be cleared.

Configuration
REQ-027 With macro WB_BYPASS_EN defined, QueryHit SHALL be 1 when any valid entry has register index == QueryReg != 0, and QueryData SHALL be the youngest such entry's data, combinationally, including the head being drained this cycle.
REQ-028 With WB_BYPASS_EN undefined, QueryHit and QueryData SHALL be tied to 0 and no compare logic SHALL be built.

Verification
REQ-029 Reset, then a single ALU offer: AluReg=5, AluData=0x1234 at edge 1 -> during cycle 2 Write1=1, WriteReg1=5, WriteData1=0x1234; Pending returns to 0 after edge 2.
REQ-030 MemValid and AluValid both high (Mem reg 3 = 0xA, ALU reg 4 = 0xB) -> Mem accepted first, AluReady=0; ALU accepted next cycle; writes issued in order r3 then r4.
REQ-031 Hold=1 with DEPTH=4 offers to r1..r4 -> Pending=4 and both Ready outputs 0; release Hold -> four consecutive Write1 cycles in order; Ready rises the cycle after the first pop.
REQ-032 Offer with AluReg=0, AluData=0xFFFF -> AluReady=1, Pending stays 0, Write1 never asserts.
REQ-033 WB_BYPASS_EN defined, Hold=1, queue holds r7=0x11 then r7=0x22, QueryReg=7 -> QueryHit=1, QueryData=0x22; QueryReg=8 -> QueryHit=0.
REQ-034 Queue holding 3 entries, RESET pulsed low between edges -> Write1=0 immediately and Pending=0; no write appears after RESET is released.
